// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back port arbiter.
package wb_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;
  localparam int STARVE_W      = 8;   // holds any STARVE_LIMIT in 1..255

  localparam logic [WB_REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_LAT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_starve_guard.sv
// Starvation guard for the long-latency requester: counts consecutive lat
// stall cycles and forces a lat win once the limit is reached.
import wb_pkg::*;

module wb_starve_guard #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lat_pending,   // lat wants the port and lost this cycle
  input  logic lat_accept,    // lat handshake completed this cycle
  output logic force_lat
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  arb_state_e          state_q;
  logic                force_lat_q;

  // Next stall count: clear on accept, saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (lat_accept)
      starve_cnt_d = '0;
    else if (lat_pending && starve_cnt_q != LIMIT)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // FSM enters FORCE_LAT on the edge the count hits the limit, so the very
  // next cycle lat wins; leaves it on the edge lat is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      state_q      <= NORMAL;
      force_lat_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        NORMAL: if (starve_cnt_d == LIMIT) begin
          state_q     <= FORCE_LAT;
          force_lat_q <= 1'b1;
        end
        FORCE_LAT: if (lat_accept) begin
          state_q     <= NORMAL;
          force_lat_q <= 1'b0;
        end
        default: begin
          state_q     <= NORMAL;
          force_lat_q <= 1'b0;
        end
      endcase
    end
  end

  assign force_lat = force_lat_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipe (fixed priority) vs long-latency
// completions, with same-rd ordering, x0 bypass and a starvation guard.
// Optional statistics counters: define WB_PORT_ARB_STATS_EN.
import wb_pkg::*;

module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_valid,
  output logic                  pipe_ready,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  lat_valid,
  output logic                  lat_ready,
  input  logic [REG_ADDR_W-1:0] lat_rd,
  input  logic [XLEN-1:0]       lat_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  pipe_wb_done,
  output logic                  lat_wb_done
`ifdef WB_PORT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      stat_pipe_grants,
  output logic [CNT_W-1:0]      stat_lat_grants,
  output logic [CNT_W-1:0]      stat_lat_stall
`endif
);

  // The request struct is sized by the package; reject mismatched builds.
  if (XLEN != WB_XLEN || REG_ADDR_W != WB_REG_ADDR_W) begin : g_width_chk
    $error("wb_port_arbiter: XLEN/REG_ADDR_W must match wb_pkg");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || CNT_W < 1) begin : g_param_chk
    $error("wb_port_arbiter: STARVE_LIMIT or CNT_W out of range");
  end

  wb_req_t pipe_req, lat_req, win_req;
  logic    pipe_x0, lat_x0, pipe_port, lat_port;
  logic    grant_pipe, grant_lat, grant_any, force_lat;

  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;
  logic                  pipe_done_q, lat_done_q;

  assign pipe_req = '{rd: pipe_rd, data: pipe_data};
  assign lat_req  = '{rd: lat_rd,  data: lat_data};

  // Classify requests: x0 writes bypass the port entirely.
  always_comb begin
    pipe_x0   = pipe_valid && (pipe_rd == REG_X0);
    lat_x0    = lat_valid  && (lat_rd  == REG_X0);
    pipe_port = pipe_valid && (pipe_rd != REG_X0);
    lat_port  = lat_valid  && (lat_rd  != REG_X0);
  end

  // Port grant: pipe has priority unless lat is starved or older on same rd.
  always_comb begin
    grant_lat  = lat_port && (!pipe_port || force_lat || (pipe_rd == lat_rd));
    grant_pipe = pipe_port && !grant_lat;
    grant_any  = grant_lat || grant_pipe;
    win_req    = grant_lat ? lat_req : pipe_req;
    pipe_ready = !reset && (pipe_x0 || grant_pipe);
    lat_ready  = !reset && (lat_x0  || grant_lat);
  end

  wb_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_guard (
    .clk         (clk),
    .reset       (reset),
    .lat_pending (lat_port && !grant_lat),
    .lat_accept  (lat_valid && lat_ready),
    .force_lat   (force_lat)
  );

  // Registered write port and done pulses; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pipe_done_q <= 1'b0;
      lat_done_q  <= 1'b0;
    end else begin
      rf_we_q     <= grant_any;
      if (grant_any) begin
        rf_waddr_q <= win_req.rd;
        rf_wdata_q <= win_req.data;
      end
      pipe_done_q <= pipe_valid && pipe_ready;
      lat_done_q  <= lat_valid && lat_ready;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign pipe_wb_done = pipe_done_q;
  assign lat_wb_done  = lat_done_q;

`ifdef WB_PORT_ARB_STATS_EN
  logic [CNT_W-1:0] pg_q, lg_q, ls_q;

  // Saturating event counters; x0 accepts are not port grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg_q <= '0;
      lg_q <= '0;
      ls_q <= '0;
    end else begin
      if (grant_pipe && pg_q != '1)             pg_q <= pg_q + 1'b1;
      if (grant_lat  && lg_q != '1)             lg_q <= lg_q + 1'b1;
      if (lat_valid && !lat_ready && ls_q != '1) ls_q <= ls_q + 1'b1;
    end
  end

  assign stat_pipe_grants = pg_q;
  assign stat_lat_grants  = lg_q;
  assign stat_lat_stall   = ls_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (STARVE_LIMIT=4).
`timescale 1ns/1ps
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, lat_valid;
  logic        pipe_ready, lat_ready;
  logic [4:0]  pipe_rd, lat_rd;
  logic [31:0] pipe_data, lat_data;
  logic        rf_we, pipe_wb_done, lat_wb_done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_PORT_ARB_STATS_EN
  logic [15:0] stat_pipe_grants, stat_lat_grants, stat_lat_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(32), .REG_ADDR_W(5), .STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_valid   (pipe_valid),
    .pipe_ready   (pipe_ready),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .lat_valid    (lat_valid),
    .lat_ready    (lat_ready),
    .lat_rd       (lat_rd),
    .lat_data     (lat_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pipe_wb_done (pipe_wb_done),
    .lat_wb_done  (lat_wb_done)
`ifdef WB_PORT_ARB_STATS_EN
    ,
    .stat_pipe_grants (stat_pipe_grants),
    .stat_lat_grants  (stat_lat_grants),
    .stat_lat_stall   (stat_lat_stall)
`endif
  );

  task automatic chk(input string tag, input logic ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    lat_valid  = lv; lat_rd  = lrd; lat_data  = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic pd, input logic ld);
    chk({tag, ".we"},    rf_we === we);
    chk({tag, ".waddr"}, rf_waddr === a);
    chk({tag, ".wdata"}, rf_wdata === d);
    chk({tag, ".pdone"}, pipe_wb_done === pd);
    chk({tag, ".ldone"}, lat_wb_done === ld);
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 5'd5, 32'h1111, 1, 5'd6, 32'h2222);
    chk("rst.pready", pipe_ready === 1'b0);
    chk("rst.lready", lat_ready === 1'b0);
    tick();
    chk_wr("rst", 0, 5'd0, 32'h0, 0, 0);
    reset = 1'b0;

    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    chk("p1.pready", pipe_ready === 1'b1);
    chk("p1.lready", lat_ready === 1'b0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk_wr("p1", 1, 5'd5, 32'hDEADBEEF, 1, 0);
    tick();
    chk_wr("idle", 0, 5'd5, 32'hDEADBEEF, 0, 0);

    drive(1, 5'd3, 32'hA3, 1, 5'd7, 32'hA7);
    chk("c.pready0", pipe_ready === 1'b1);
    chk("c.lready0", lat_ready === 1'b0);
    tick();
    chk_wr("c.w3", 1, 5'd3, 32'hA3, 1, 0);
    drive(0, 5'd0, 32'h0, 1, 5'd7, 32'hA7);
    chk("c.lready1", lat_ready === 1'b1);
    tick();
    chk_wr("c.w7", 1, 5'd7, 32'hA7, 0, 1);

    drive(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
    chk("s.lready", lat_ready === 1'b1);
    chk("s.pready0", pipe_ready === 1'b0);
    tick();
    chk_wr("s.lat", 1, 5'd9, 32'h2, 0, 1);
    drive(1, 5'd9, 32'h1, 0, 5'd0, 32'h0);
    chk("s.pready1", pipe_ready === 1'b1);
    tick();
    chk_wr("s.pipe", 1, 5'd9, 32'h1, 1, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();

    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'(k), 32'(k), 1, 5'd20, 32'hCAFE);
      chk($sformatf("st.lstall%0d", k), lat_ready === 1'b0);
      chk($sformatf("st.pgo%0d", k), pipe_ready === 1'b1);
      tick();
      chk_wr($sformatf("st.w%0d", k), 1, 5'(k), 32'(k), 1, 0);
    end
    drive(1, 5'd11, 32'hB, 1, 5'd20, 32'hCAFE);
    chk("st.force.l", lat_ready === 1'b1);
    chk("st.force.p", pipe_ready === 1'b0);
    tick();
    chk_wr("st.lat", 1, 5'd20, 32'hCAFE, 0, 1);
    drive(1, 5'd11, 32'hB, 1, 5'd21, 32'hD);
    chk("st.norm.p", pipe_ready === 1'b1);
    chk("st.norm.l", lat_ready === 1'b0);
    tick();
    chk_wr("st.p11", 1, 5'd11, 32'hB, 1, 0);
    drive(0, 5'd0, 32'h0, 1, 5'd21, 32'hD);
    chk("st.l21", lat_ready === 1'b1);
    tick();
    chk_wr("st.w21", 1, 5'd21, 32'hD, 0, 1);

    drive(1, 5'd0, 32'h55, 1, 5'd4, 32'h44);
    chk("x0.pready", pipe_ready === 1'b1);
    chk("x0.lready", lat_ready === 1'b1);
    tick();
    chk_wr("x0", 1, 5'd4, 32'h44, 1, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();
    chk_wr("x0.idle", 0, 5'd4, 32'h44, 0, 0);

    for (int k = 1; k <= 3; k++) begin
      drive(1, 5'd2, 32'(k), 1, 5'd6, 32'h66);
      chk($sformatf("rs.pre%0d", k), lat_ready === 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(1, 5'd2, 32'h9, 1, 5'd6, 32'h66);
    chk("rs.pready", pipe_ready === 1'b0);
    tick();
    chk_wr("rs", 0, 5'd0, 32'h0, 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'd2, 32'(k), 1, 5'd6, 32'h66);
      chk($sformatf("rs.stall%0d", k), lat_ready === 1'b0);
      tick();
    end
    drive(1, 5'd2, 32'h5, 1, 5'd6, 32'h66);
    chk("rs.force", lat_ready === 1'b1);
    tick();
    chk_wr("rs.lat", 1, 5'd6, 32'h66, 0, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
